// File: rtl/comp42_serial_ctrl.sv
// Bit-serial 4:2 reduction of four unsigned operands into a redundant sum/carry pair.
// Define COMP42_FINAL_ADD_EN to insert a one-cycle ADD state that forms the carry-propagate result.
module comp42_serial_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_c,
  input  logic [WIDTH-1:0] op_d,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum_vec,
  output logic [WIDTH:0]   carry_vec,
  output logic [WIDTH+1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef COMP42_FINAL_ADD_EN
    S_ADD  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  // One 4:2 compressor column: two chained full adders; {cout, carry, sum}.
  function automatic logic [2:0] compress42(input logic x1, input logic x2, input logic x3,
                                            input logic x4, input logic cin);
    logic s1, c1, s2, c2;
    s1 = x1 ^ x2 ^ x3;
    c1 = (x1 & x2) | (x1 & x3) | (x2 & x3);
    s2 = s1 ^ x4 ^ cin;
    c2 = (s1 & x4) | (s1 & cin) | (x4 & cin);
    return {c1, c2, s2};
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [WIDTH:0]   sum_vec_q, sum_vec_d, carry_vec_q, carry_vec_d;
  logic             last_col;
  logic [2:0]       col_out;

  assign last_col = (col_q == CW'(WIDTH));

  // The extension column zeroes the operand bits so only the final Cin lands in it.
  assign col_out = compress42(a_q[0] & ~last_col, b_q[0] & ~last_col,
                              c_q[0] & ~last_col, d_q[0] & ~last_col, cin_q);

`ifdef COMP42_FINAL_ADD_EN
  logic [WIDTH+1:0] result_q, result_d;
  assign result = result_q;
`else
  assign result = '0;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cin_d       = cin_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    sum_vec_d   = sum_vec_q;
    carry_vec_d = carry_vec_q;
`ifdef COMP42_FINAL_ADD_EN
    result_d    = result_q;
`endif
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_d         = op_a;
            b_d         = op_b;
            c_d         = op_c;
            d_d         = op_d;
            col_d       = '0;
            cin_d       = 1'b0;
            sum_vec_d   = '0;
            carry_vec_d = '0;
            state_d     = S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i <= WIDTH; i++) begin
            if (col_q == CW'(i)) begin
              sum_vec_d[i]   = col_out[0];
              carry_vec_d[i] = col_out[1];
            end
          end
          cin_d = col_out[2];
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          c_d   = c_q >> 1;
          d_d   = d_q >> 1;
          col_d = col_q + CW'(1);
          if (last_col) begin
`ifdef COMP42_FINAL_ADD_EN
            state_d = S_ADD;
`else
            state_d = S_DONE;
`endif
          end
        end
`ifdef COMP42_FINAL_ADD_EN
        S_ADD: begin
          result_d = {1'b0, sum_vec_q} + {carry_vec_q, 1'b0};
          state_d  = S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      cin_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      sum_vec_q   <= '0;
      carry_vec_q <= '0;
`ifdef COMP42_FINAL_ADD_EN
      result_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cin_q       <= cin_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      sum_vec_q   <= sum_vec_d;
      carry_vec_q <= carry_vec_d;
`ifdef COMP42_FINAL_ADD_EN
      result_q    <= result_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum_vec   = sum_vec_q;
  assign carry_vec = carry_vec_q;

endmodule

// File: tb/tb_comp42_serial_ctrl.sv
// Scoreboard bench for comp42_serial_ctrl: expected totals are queued at acceptance and
// checked by an independent monitor whenever out_valid is presented.
module tb_comp42_serial_ctrl;

  localparam int WIDTH = 8;
`ifdef COMP42_FINAL_ADD_EN
  localparam int LAT    = WIDTH + 2;
  localparam bit ADD_EN = 1'b1;
`else
  localparam int LAT    = WIDTH + 1;
  localparam bit ADD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0, op_c = '0, op_d = '0;
  logic             in_ready, out_valid, busy;
  logic [WIDTH:0]   sum_vec, carry_vec;
  logic [WIDTH+1:0] result;

  comp42_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .sum_vec(sum_vec),
    .carry_vec(carry_vec), .result(result), .busy(busy)
  );

  typedef struct {
    logic [WIDTH+1:0] total;
    int               t_acc;
    bit               exact;
    logic [WIDTH:0]   es;
    logic [WIDTH:0]   ec;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0;
  int n_pushed = 0, n_consumed = 0, valid_count = 0, ready_mode = 0;
  bit seen = 1'b0, idle_chk = 1'b0;
  logic [WIDTH:0]   held_sum, held_carry;
  logic [WIDTH+1:0] held_result;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_sum_vec"}, 32'(sum_vec), 32'd0);
    checkOutput({tag, "_carry_vec"}, 32'(carry_vec), 32'd0);
    checkOutput({tag, "_result"}, 32'(result), 32'd0);
  endtask

  // Accepts one operand set, queues its expectation and waits until it is consumed.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                               input bit exact, input logic [WIDTH:0] es,
                               input logic [WIDTH:0] ec, input bit flush_at_accept);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    flush    = flush_at_accept;
    op_a = a; op_b = b; op_c = c; op_d = d;
    e.total = (WIDTH+2)'(a) + (WIDTH+2)'(b) + (WIDTH+2)'(c) + (WIDTH+2)'(d);
    e.t_acc = cyc + 1;
    e.exact = exact;
    e.es    = es;
    e.ec    = ec;
    sb.push_back(e);
    n_pushed++;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
    op_c = WIDTH'($urandom); op_d = WIDTH'($urandom);
    n = 0;
    while (n_consumed < n_pushed && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n_consumed < n_pushed) begin
      checkOutput("done_timeout", 32'(n_consumed), 32'(n_pushed));
      sb.delete();
      n_consumed = n_pushed;
    end
  endtask

  // Starts an operation that is aborted at column 3 by flush (or by reset).
  task automatic abortRun(input bit use_reset);
    int t;
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
    op_c = WIDTH'($urandom); op_d = WIDTH'($urandom);
    t = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < t + 3) @(negedge clk);
    checkOutput("busy_mid_run", 32'(busy), 32'd1);
    if (use_reset) begin
      rst_n = 1'b0;
      @(negedge clk);
      checkReset("mid_run_reset");
      rst_n = 1'b1;
    end else begin
      flush    = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
      checkOutput("flush_busy", 32'(busy), 32'd0);
      checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    end
    repeat (LAT + 4) @(negedge clk);
  endtask

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (valid_count >= 5);
    endcase
  end

  // Monitor: pops the scoreboard on each new out_valid and checks hold stability.
  initial begin
    exp_t e;
    logic [WIDTH+1:0] recon;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        valid_count = 0;
        idle_chk = 1'b0;
      end else begin
        if (idle_chk) begin
          checkOutput("in_ready_after_done", 32'(in_ready), 32'd1);
          checkOutput("out_valid_after_done", 32'(out_valid), 32'd0);
          idle_chk = 1'b0;
        end
        if (out_valid) begin
          if (!seen) begin
            if (sb.size() == 0) begin
              checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
              e = sb.pop_front();
              recon = {1'b0, sum_vec} + {carry_vec, 1'b0};
              checkOutput("sum_plus_2carry", 32'(recon), 32'(e.total));
              checkOutput("ext_carry_zero", 32'(carry_vec[WIDTH]), 32'd0);
              checkOutput("latency", 32'(cyc), 32'(e.t_acc + LAT));
              checkOutput("result", 32'(result), ADD_EN ? 32'(e.total) : 32'd0);
              if (e.exact) begin
                checkOutput("sum_vec_exact", 32'(sum_vec), 32'(e.es));
                checkOutput("carry_vec_exact", 32'(carry_vec), 32'(e.ec));
              end
            end
            held_sum    = sum_vec;
            held_carry  = carry_vec;
            held_result = result;
            seen        = 1'b1;
            valid_count = 0;
          end else begin
            checkOutput("hold_sum_vec", 32'(sum_vec), 32'(held_sum));
            checkOutput("hold_carry_vec", 32'(carry_vec), 32'(held_carry));
            checkOutput("hold_result", 32'(result), 32'(held_result));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_busy", 32'(busy), 32'd1);
          end
          valid_count++;
          if (out_ready) begin
            seen        = 1'b0;
            valid_count = 0;
            n_consumed++;
            idle_chk    = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] ra, rb, rc, rd;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    ready_mode = 0;
    applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 9'h000, 9'h000, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 9'h000, 9'h000, 1'b0);
    applyStimulus(8'h01, 8'h02, 8'h04, 8'h08, 1'b1, 9'h00F, 9'h000, 1'b0);

    ready_mode = 2;
    applyStimulus(8'h5A, 8'hC3, 8'h0F, 8'hF0, 1'b0, 9'h000, 9'h000, 1'b0);

    ready_mode = 0;
    abortRun(1'b0);
    applyStimulus(8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0, 9'h000, 9'h000, 1'b0);
    applyStimulus(8'h81, 8'h7E, 8'h33, 8'hCC, 1'b0, 9'h000, 9'h000, 1'b1);

    abortRun(1'b1);
    ready_mode = 1;
    applyStimulus(8'h10, 8'h10, 8'h10, 8'h10, 1'b0, 9'h000, 9'h000, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      rc = WIDTH'($urandom); rd = WIDTH'($urandom);
      applyStimulus(ra, rb, rc, rd, 1'b0, 9'h000, 9'h000, 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
